// File: rtl/counter.sv
// rtl/counter.sv - loadable, enabled, wrap-around up-counter (rst > load > enab)
// Optional registered wrap flag output when COUNTER_WRAP_FLAG_EN is defined.
module counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enab,
    input  logic [WIDTH-1:0] cnt_in,
`ifdef COUNTER_WRAP_FLAG_EN
    output logic             wrap,
`endif
    output logic [WIDTH-1:0] cnt_out
);

    logic at_max;

    assign at_max = &cnt_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_out <= '0;
        end else if (load) begin
            cnt_out <= cnt_in;
        end else if (enab) begin
            cnt_out <= cnt_out + WIDTH'(1);
        end
    end

`ifdef COUNTER_WRAP_FLAG_EN
    // Flag marks only the increment that rolls all-ones over to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap <= 1'b0;
        end else begin
            wrap <= !load && enab && at_max;
        end
    end
`else
    logic unused_at_max;
    assign unused_at_max = at_max;
`endif

endmodule

// File: tb/tb_counter.sv
// tb/tb_counter.sv - scoreboard bench for counter (WIDTH=5), optional COUNTER_WRAP_FLAG_EN
module tb_counter;

    localparam int W = 5;

    typedef struct {
        logic [W-1:0] c;
        logic         w;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         load = 1'b0;
    logic         enab = 1'b0;
    logic [W-1:0] cnt_in = '0;
    logic [W-1:0] cnt_out;
    logic         wrap_obs;

    exp_t         sb_q[$];
    logic [W-1:0] model = '0;
    int           total = 0;
    int           bad = 0;

    counter #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .enab    (enab),
        .cnt_in  (cnt_in),
`ifdef COUNTER_WRAP_FLAG_EN
        .wrap    (wrap_obs),
`endif
        .cnt_out (cnt_out)
    );

`ifndef COUNTER_WRAP_FLAG_EN
    assign wrap_obs = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic compare_pending(input string tag);
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, "_cnt"}, 32'(cnt_out), 32'(e.c));
`ifdef COUNTER_WRAP_FLAG_EN
            check({tag, "_wrap"}, 32'(wrap_obs), 32'(e.w));
`endif
        end
    endtask

    // Check the previous cycle's result, then apply new inputs and queue their expectation.
    task automatic drive(input string tag, input logic r, input logic l, input logic e,
                         input logic [W-1:0] d, input logic [W-1:0] exp_c, input logic exp_w);
        exp_t x;
        @(negedge clk);
        compare_pending(tag);
        rst = r; load = l; enab = e; cnt_in = d;
        x.c = exp_c;
        x.w = exp_w;
        sb_q.push_back(x);
        model = exp_c;
    endtask

    initial begin
        drive("reset",   1, 0, 0, 5'h00, 5'h00, 0);
        drive("ld15",    0, 1, 1, 5'h15, 5'h15, 0);
        drive("ld0a",    0, 1, 1, 5'h0A, 5'h0A, 0);
        drive("ld1f",    0, 1, 1, 5'h1F, 5'h1F, 0);
        drive("rst_ld",  1, 1, 1, 5'h1F, 5'h00, 0);
        drive("ld1f_b",  0, 1, 0, 5'h1F, 5'h1F, 0);
        drive("wrap",    0, 0, 1, 5'h00, 5'h00, 1);
        drive("wrap_hold", 0, 0, 0, 5'h00, 5'h00, 0);
        drive("ld_zero", 0, 1, 0, 5'h00, 5'h00, 0);
        drive("ld03",    0, 1, 0, 5'h03, 5'h03, 0);
        for (int i = 0; i < 4; i++)
            drive("inc", 0, 0, 1, 5'h00, 5'h04 + 5'(i), 0);
        drive("hold1",   0, 0, 0, 5'h00, 5'h07, 0);
        drive("hold2",   0, 0, 0, 5'h00, 5'h07, 0);
        drive("ld0f",    0, 1, 0, 5'h0F, 5'h0F, 0);
        drive("cnt10",   0, 0, 1, 5'h00, 5'h10, 0);
        drive("mid_rst", 1, 0, 1, 5'h00, 5'h00, 0);
        drive("post_rst", 0, 0, 1, 5'h00, 5'h01, 0);
        drive("idle_1f", 0, 0, 0, 5'h1F, 5'h01, 0);
        drive("idle_0a", 0, 0, 0, 5'h0A, 5'h01, 0);
        drive("idle_15", 0, 0, 0, 5'h15, 5'h01, 0);

        // Randomised traffic against a behavioural model, biased towards counting.
        for (int i = 0; i < 60; i++) begin
            logic r, l, e, w;
            logic [W-1:0] d, nxt;
            r = ($urandom_range(0, 15) == 0);
            l = ($urandom_range(0, 7) == 0);
            e = ($urandom_range(0, 3) != 0);
            d = W'($urandom_range(0, 31));
            w = 1'b0;
            if (r) nxt = '0;
            else if (l) nxt = d;
            else if (e) begin
                nxt = model + 5'd1;
                w = (model == 5'h1F);
            end else nxt = model;
            drive("rand", r, l, e, d, nxt, w);
        end

        @(negedge clk);
        compare_pending("final");
        check("queue_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
